// File: rtl/pe_convert_pipe_if.sv
// pe_convert_pipe_if: ready/valid stream bundle for pe_convert_pipe.
// out_inexact exists only when PE_CONV_INEXACT_EN is defined.
interface pe_convert_pipe_if #(parameter int NUM_LANES = 2);
    logic [NUM_LANES*64-1:0] in_data;
    logic [1:0]              in_op;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_LANES*64-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
`ifdef PE_CONV_INEXACT_EN
    logic [NUM_LANES-1:0]    out_inexact;
    modport master (output in_data, in_op, in_valid, out_ready, input in_ready, out_data, out_valid, out_inexact);
    modport slave (input in_data, in_op, in_valid, out_ready, output in_ready, out_data, out_valid, out_inexact);
`else
    modport master (output in_data, in_op, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave (input in_data, in_op, in_valid, out_ready, output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/pe_convert_pipe.sv
// pe_convert_pipe: multi-lane op-tagged int64->double converter with credit-protected output FIFO.
// Define PE_CONV_INEXACT_EN to add the per-lane out_inexact flag.
module pe_convert_pipe #(
    parameter int NUM_LANES  = 2,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    pe_convert_pipe_if.slave bus
);
    localparam int W  = NUM_LANES * 64;
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef PE_CONV_INEXACT_EN
    localparam int PW = W + NUM_LANES;
`else
    localparam int PW = W;
`endif

    // {sign, leading-zero count, magnitude shifted so its msb sits at bit 63}
    function automatic logic [70:0] normalise(input logic [63:0] x, input logic sgn);
        logic [63:0] mag;
        logic [5:0]  lz;
        mag = (sgn && x[63]) ? -x : x;
        lz = 6'd0;
        for (int i = 0; i < 64; i++) if (mag[i]) lz = 6'(63 - i);
        return {sgn && x[63], lz, mag << lz};
    endfunction

    // A carry out of the mantissa leaves sum[51:0] all zero, so the fraction needs no shift.
    function automatic logic [63:0] to_double(input logic [63:0] x, input logic sgn);
        logic [70:0] n;
        logic        inc;
        logic [53:0] sum;
        n = normalise(x, sgn);
        inc = n[10] & (n[9] | (|n[8:0]) | n[11]);
        sum = {1'b0, n[63:11]} + 54'(inc);
        return n[63] ? {n[70], 11'd1086 - 11'(n[69:64]) + 11'(sum[53]), sum[51:0]} : 64'd0;
    endfunction

`ifdef PE_CONV_INEXACT_EN
    function automatic logic lossy(input logic [63:0] x, input logic sgn);
        logic [70:0] n;
        n = normalise(x, sgn);
        return |n[10:0];
    endfunction
`endif

    logic               accept, pop, push;
    logic [LATENCY-1:0] vld_q;
    logic [W-1:0]       raw_q;
    logic [1:0]         op_q;
    logic [PW-1:0]      pay_d;
    logic [PW-1:0]      pay_q [1:LATENCY-1];
    logic [PW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q, cred_q;

    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = vld_q[LATENCY-1];
    assign bus.in_ready  = !rst && cred_q != '0;
    assign bus.out_valid = !rst && cnt_q != '0;
    assign bus.out_data  = bus.out_valid ? mem_q[rd_q][W-1:0] : '0;
`ifdef PE_CONV_INEXACT_EN
    assign bus.out_inexact = bus.out_valid ? mem_q[rd_q][W +: NUM_LANES] : '0;
`endif

    always_comb begin
        pay_d = '0;
        pay_d[W-1:0] = raw_q;
        if (op_q == 2'b01 || op_q == 2'b10)
            for (int i = 0; i < NUM_LANES; i++) begin
                pay_d[64*i +: 64] = to_double(raw_q[64*i +: 64], op_q[0]);
`ifdef PE_CONV_INEXACT_EN
                pay_d[W+i] = lossy(raw_q[64*i +: 64], op_q[0]);
`endif
            end
    end

    // Data stages carry no reset; the valid shift register alone marks live beats.
    always_ff @(posedge clk) begin
        vld_q <= rst ? '0 : {vld_q[LATENCY-2:0], accept};
        raw_q <= bus.in_data;
        op_q <= bus.in_op;
        pay_q[1] <= pay_d;
        for (int i = 2; i < LATENCY; i++) pay_q[i] <= pay_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            cred_q <= CW'(FIFO_DEPTH);
        end else begin
            if (push) mem_q[wr_q] <= pay_q[LATENCY-1];
            if (push) wr_q <= wr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1;
            if (pop) rd_q <= rd_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            cred_q <= cred_q - CW'(accept) + CW'(pop);
        end
    end
endmodule

// File: tb/tb_pe_convert_pipe.sv
// tb_pe_convert_pipe: scoreboard bench for pe_convert_pipe; inputs driven 1ns after posedge.
module tb_pe_convert_pipe;
    localparam int L = 4;
    localparam int D = 8;
    localparam int W = 128;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [1:0]   inx;
        logic [W-1:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    int    seen = 0;
    beat_t exp_q [$];
    beat_t ent;

    pe_convert_pipe_if #(.NUM_LANES(2)) bus ();
    pe_convert_pipe #(.NUM_LANES(2), .LATENCY(L), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stray_beat: got %h, required no beat", bus.out_data);
            end else begin
                ent = exp_q.pop_front();
                if (bus.out_data !== ent.data) begin
                    errors++;
                    $display("FAIL beat%0d_data: got %h, required %h", seen, bus.out_data, ent.data);
                end
`ifdef PE_CONV_INEXACT_EN
                checks++;
                if (bus.out_inexact !== ent.inx) begin
                    errors++;
                    $display("FAIL beat%0d_inexact: got %b, required %b", seen, bus.out_inexact, ent.inx);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic [W-1:0] e, input logic [1:0] x);
        int n = 0;
        bus.in_data = d;
        bus.in_op = op;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b, required 1", bus.in_ready);
        end else exp_q.push_back({x, e});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h, required 0", bus.out_data); end
        rst = 1'b0;
        tick();
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b, required 0", bus.out_valid); end
    endtask

    task automatic test_signed_latency();
        int n = 1;
        bus.in_data = {ONES, 64'd1};
        bus.in_op = 2'b01;
        bus.in_valid = 1'b1;
        exp_q.push_back({2'b00, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000});
        tick();
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != L + 1) begin errors++; $display("FAIL latency: got %0d cycles, required %0d", n, L + 1); end
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL signed_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_extremes_rounding();
        send({64'd0, 64'h8000_0000_0000_0000}, 2'b01, {64'd0, 64'hC3E0_0000_0000_0000}, 2'b00);
        send({64'd1, 64'h0020_0000_0000_0001}, 2'b01, {64'h3FF0_0000_0000_0000, 64'h4340_0000_0000_0000}, 2'b01);
        send({64'h8000_0000_0000_0000, ONES}, 2'b10, {64'h43E0_0000_0000_0000, 64'h43F0_0000_0000_0000}, 2'b01);
        send({ONES - 64'd1, 64'h0020_0000_0000_0003}, 2'b01, {64'hC000_0000_0000_0000, 64'h4340_0000_0000_0002}, 2'b01);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL extremes_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_interleaved();
        send({ONES, ONES}, 2'b00, {ONES, ONES}, 2'b00);
        send({ONES, ONES}, 2'b01, {2{64'hBFF0_0000_0000_0000}}, 2'b00);
        send({ONES, ONES}, 2'b10, {2{64'h43F0_0000_0000_0000}}, 2'b11);
        send({ONES, ONES}, 2'b00, {ONES, ONES}, 2'b00);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL interleave_drain: %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int base = seen;
        logic [W-1:0] d [20];
        for (int i = 0; i < 20; i++) d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        while (acc < 20 && bus.in_ready) begin
            bus.in_data = d[acc];
            bus.in_op = acc[0] ? 2'b11 : 2'b00;
            exp_q.push_back({2'b00, d[acc]});
            acc++;
            tick();
        end
        bus.in_data = d[acc];
        bus.in_op = acc[0] ? 2'b11 : 2'b00;
        checks++;
        if (acc != D) begin errors++; $display("FAIL bp_accepts: got %0d, required %0d", acc, D); end
        repeat (5) tick();
        checks += 3;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b, required 1", bus.out_valid); end
        if (seen != base) begin errors++; $display("FAIL bp_stall_pops: got %0d, required 0", seen - base); end
        bus.out_ready = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready: got %b, required 0", bus.in_ready); end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_back: got %b, required 1", bus.in_ready); end
        for (int n = 0; n < 200 && acc < 20; n++) begin
            bus.in_data = d[acc];
            bus.in_op = acc[0] ? 2'b11 : 2'b00;
            if (bus.in_ready) begin
                exp_q.push_back({2'b00, d[acc]});
                acc++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d beats left, required 0", exp_q.size()); end
        if (seen - base != 20) begin errors++; $display("FAIL bp_count: got %0d beats, required 20", seen - base); end
    endtask

    task automatic test_reset_midflight();
        int base;
        for (int i = 0; i < 3; i++) send({64'd1, 64'd1}, 2'b01, {2{64'h3FF0_0000_0000_0000}}, 2'b00);
        rst = 1'b1;
        exp_q.delete();
        base = seen;
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h, required 0", bus.out_data); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b, required 1", bus.in_ready); end
        repeat (10) tick();
        checks += 2;
        if (seen != base) begin errors++; $display("FAIL stale_beats: got %0d, required 0", seen - base); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b, required 0", bus.out_valid); end
        send({ONES, 64'd1}, 2'b01, {64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000}, 2'b00);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        checks++;
        if (seen - base != 1) begin errors++; $display("FAIL post_rst_beat: got %0d beats, required 1", seen - base); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_op = 2'b00;
        bus.out_ready = 1'b1;
        test_reset();
        test_signed_latency();
        test_extremes_rounding();
        test_interleaved();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
